// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the synchronous-read instruction memory.
// Parity storage is enabled by defining INST_MEM_PARITY_EN.
package inst_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } st_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Word aligned and inside the 2**depth_log2 word window starting at 0.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_log2);
        logic [31:0] hi;
        hi = addr >> (depth_log2 + 32'd2);
        return (addr[1:0] == 2'b00) && (hi == 32'd0);
    endfunction

    // Even parity over a zero-extended word.
    function automatic logic parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single write port, single synchronous read port storage array.
// A read and a write to the same index on one edge returns the new data.
module inst_mem_array #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/inst_mem_sync.sv
// IF-stage instruction memory: self-clearing FSM, registered fetch with flush/stall, load port.
// Defining INST_MEM_PARITY_EN adds a stored parity bit per word and the ParityErr output.
module inst_mem_sync
    import inst_mem_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 8,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Addr,
    input  logic              FetchEn,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] Inst,
    output logic [31:0]       InstPC,
    output logic              InstValid,
    output logic              AddrErr,
    output logic              Ready,
`ifdef INST_MEM_PARITY_EN
    output logic              ParityErr,
`endif
    input  logic              LoadEn,
    input  logic [31:0]       LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    output logic              LoadAck
);

`ifdef INST_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    st_e                   state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ready_q;

    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [31:0]           pc_q, pc_d;
    logic                  ack_q, ack_d;

    logic                  fetch_ok, load_ok, load_go;
    logic                  mem_we, mem_re;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [DATA_W-1:0]     wr_word;
    logic [MEM_W-1:0]      mem_wdata, mem_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_q == ST_READY);
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Output / datapath control; everything is gated on Ready so fetch and load open together.
    always_comb begin
        fetch_ok  = addr_ok(Addr, DEPTH_LOG2);
        load_ok   = addr_ok(LoadAddr, DEPTH_LOG2);
        load_go   = ready_q && LoadEn && load_ok;

        mem_we    = load_go || (state_q == ST_CLEAR);
        mem_waddr = (state_q == ST_CLEAR) ? clr_cnt_q : LoadAddr[DEPTH_LOG2+1:2];
        wr_word   = (state_q == ST_CLEAR) ? NOP_WORD : LoadData;
        mem_re    = ready_q && !Flush && !Stall && FetchEn && fetch_ok;

        valid_d   = valid_q;
        err_d     = err_q;
        pc_d      = pc_q;
        ack_d     = load_go;

        if (!ready_q) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (Flush) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            pc_d    = Addr;
        end else if (Stall) begin
            valid_d = valid_q;
        end else if (FetchEn) begin
            valid_d = fetch_ok;
            err_d   = !fetch_ok;
            pc_d    = Addr;
        end else begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic par_bad;
    assign mem_wdata = {parity(64'(wr_word)), wr_word};
    assign par_bad   = valid_q && (parity(64'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W]);
    assign ParityErr = par_bad;
    assign InstValid = valid_q && !par_bad;
`else
    assign mem_wdata = wr_word;
    assign InstValid = valid_q;
`endif

    assign Inst    = InstValid ? mem_rdata[DATA_W-1:0] : NOP_WORD;
    assign InstPC  = pc_q;
    assign AddrErr = err_q;
    assign Ready   = ready_q;
    assign LoadAck = ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            pc_q    <= 32'd0;
            ack_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
            ack_q   <= ack_d;
        end
    end

    inst_mem_array #(
        .WIDTH      (MEM_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (Addr[DEPTH_LOG2+1:2]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync with a 16-word memory.
module tb_inst_mem_sync;

    localparam int unsigned DW = 32;
    localparam int unsigned DL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   Addr;
    logic          FetchEn, Stall, Flush;
    logic [DW-1:0] Inst;
    logic [31:0]   InstPC;
    logic          InstValid, AddrErr, Ready;
    logic          LoadEn;
    logic [31:0]   LoadAddr;
    logic [DW-1:0] LoadData;
    logic          LoadAck;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    inst_mem_sync #(
        .DATA_W     (DW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .FetchEn   (FetchEn),
        .Stall     (Stall),
        .Flush     (Flush),
        .Inst      (Inst),
        .InstPC    (InstPC),
        .InstValid (InstValid),
        .AddrErr   (AddrErr),
        .Ready     (Ready),
        .LoadEn    (LoadEn),
        .LoadAddr  (LoadAddr),
        .LoadData  (LoadData),
        .LoadAck   (LoadAck)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        FetchEn = 1'b0; Stall = 1'b0; Flush = 1'b0; LoadEn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; Addr = 32'd0; LoadAddr = 32'd0; LoadData = '0;
        idle();
        step(); step();
        n_total++;
        if ({Ready, InstValid, AddrErr, LoadAck} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {Ready, InstValid, AddrErr, LoadAck});
        else n_pass++;
        n_total++;
        if (Inst !== 32'd0 || InstPC !== 32'd0)
            $display("FAIL reset_inst got %h/%h want 0/0", Inst, InstPC);
        else n_pass++;
    endtask

    task automatic test_clear();
        int bad;
        bad = 0;
        rst = 1'b0;
        FetchEn = 1'b1; Addr = 32'h8;
        LoadEn = 1'b1; LoadAddr = 32'h8; LoadData = 32'hAAAA5555;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (Ready !== 1'b0 || InstValid !== 1'b0 || LoadAck !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL clear_window bad_edges %0d want 0", bad);
        else n_pass++;
        idle();
        step();
        n_total++;
        if (Ready !== 1'b1) $display("FAIL ready_edge17 got %b want 1", Ready);
        else n_pass++;
        // Load issued during CLEAR must not have landed
        FetchEn = 1'b1; Addr = 32'h8;
        step();
        n_total++;
        if (Inst !== 32'd0 || InstValid !== 1'b1)
            $display("FAIL clear_drop_load got %h/%b want 0/1", Inst, InstValid);
        else n_pass++;
        idle();
    endtask

    task automatic test_load_fetch();
        LoadEn = 1'b1; LoadAddr = 32'h0; LoadData = 32'h34010001;
        step();
        n_total++;
        if (LoadAck !== 1'b1) $display("FAIL load_ack got %b want 1", LoadAck);
        else n_pass++;
        LoadEn = 1'b0; FetchEn = 1'b1; Addr = 32'h0;
        step();
        n_total++;
        if (LoadAck !== 1'b0) $display("FAIL load_ack_pulse got %b want 0", LoadAck);
        else n_pass++;
        n_total++;
        if (Inst !== 32'h34010001 || InstPC !== 32'h0 || InstValid !== 1'b1 || AddrErr !== 1'b0)
            $display("FAIL fetch0 got %h/%h/%b/%b want 34010001/0/1/0",
                     Inst, InstPC, InstValid, AddrErr);
        else n_pass++;
        idle();
    endtask

    task automatic test_stall();
        LoadEn = 1'b1; LoadAddr = 32'h4; LoadData = 32'h24020002;
        step();
        LoadEn = 1'b0; FetchEn = 1'b1; Addr = 32'h0;
        step();
        Stall = 1'b1; Addr = 32'h4;
        step();
        n_total++;
        if (Inst !== 32'h34010001 || InstPC !== 32'h0 || InstValid !== 1'b1)
            $display("FAIL stall_hold got %h/%h/%b want 34010001/0/1", Inst, InstPC, InstValid);
        else n_pass++;
        Stall = 1'b0;
        step();
        n_total++;
        if (Inst !== 32'h24020002 || InstPC !== 32'h4 || InstValid !== 1'b1)
            $display("FAIL after_stall got %h/%h/%b want 24020002/4/1", Inst, InstPC, InstValid);
        else n_pass++;
        idle();
    endtask

    task automatic test_flush();
        LoadEn = 1'b1; LoadAddr = 32'h1C; LoadData = 32'hDEADBEEF;
        step();
        LoadEn = 1'b0; FetchEn = 1'b1; Addr = 32'h1C; Flush = 1'b1; Stall = 1'b1;
        step();
        n_total++;
        if (Inst !== 32'd0 || InstValid !== 1'b0 || InstPC !== 32'h1C || AddrErr !== 1'b0)
            $display("FAIL flush_wins got %h/%b/%h/%b want 0/0/1c/0",
                     Inst, InstValid, InstPC, AddrErr);
        else n_pass++;
        idle();
        // Idle cycle: output drops to NOP but InstPC holds
        FetchEn = 1'b1; Addr = 32'h1C;
        step();
        FetchEn = 1'b0; Addr = 32'h8;
        step();
        n_total++;
        if (Inst !== 32'd0 || InstValid !== 1'b0 || InstPC !== 32'h1C)
            $display("FAIL fetch_idle got %h/%b/%h want 0/0/1c", Inst, InstValid, InstPC);
        else n_pass++;
    endtask

    task automatic test_addr_err();
        FetchEn = 1'b1; Addr = 32'h2;
        step();
        n_total++;
        if (AddrErr !== 1'b1 || InstValid !== 1'b0 || Inst !== 32'd0 || InstPC !== 32'h2)
            $display("FAIL misaligned got %b/%b/%h/%h want 1/0/0/2", AddrErr, InstValid, Inst, InstPC);
        else n_pass++;
        Addr = 32'h400;
        step();
        n_total++;
        if (AddrErr !== 1'b1 || InstValid !== 1'b0 || Inst !== 32'd0)
            $display("FAIL range_400 got %b/%b/%h want 1/0/0", AddrErr, InstValid, Inst);
        else n_pass++;
        Addr = 32'h40;
        step();
        n_total++;
        if (AddrErr !== 1'b1 || InstValid !== 1'b0)
            $display("FAIL range_40 got %b/%b want 1/0", AddrErr, InstValid);
        else n_pass++;
        FetchEn = 1'b0;
        LoadEn = 1'b1; LoadAddr = 32'h400; LoadData = 32'h55555555;
        step();
        n_total++;
        if (LoadAck !== 1'b0 || AddrErr !== 1'b0)
            $display("FAIL load_400 got ack %b err %b want 0 0", LoadAck, AddrErr);
        else n_pass++;
        LoadAddr = 32'h2;
        step();
        n_total++;
        if (LoadAck !== 1'b0) $display("FAIL load_misaligned got %b want 0", LoadAck);
        else n_pass++;
        // 0x400 aliases idx 0 and 0x2 hits idx 0; neither may have written
        LoadEn = 1'b0; FetchEn = 1'b1; Addr = 32'h0;
        step();
        n_total++;
        if (Inst !== 32'h34010001 || InstValid !== 1'b1)
            $display("FAIL no_alias got %h/%b want 34010001/1", Inst, InstValid);
        else n_pass++;
        Addr = 32'h3C;
        step();
        n_total++;
        if (AddrErr !== 1'b0 || InstValid !== 1'b1 || Inst !== 32'd0)
            $display("FAIL top_word got %b/%b/%h want 0/1/0", AddrErr, InstValid, Inst);
        else n_pass++;
        idle();
    endtask

    task automatic test_collision();
        LoadEn = 1'b1; LoadAddr = 32'hC; LoadData = 32'h08000003;
        FetchEn = 1'b1; Addr = 32'hC;
        step();
        n_total++;
        if (Inst !== 32'h08000003 || InstValid !== 1'b1 || LoadAck !== 1'b1)
            $display("FAIL write_first got %h/%b/%b want 08000003/1/1", Inst, InstValid, LoadAck);
        else n_pass++;
        Stall = 1'b1; LoadData = 32'h11111111;
        step();
        n_total++;
        if (Inst !== 32'h08000003 || InstPC !== 32'hC)
            $display("FAIL stall_vs_load got %h/%h want 08000003/c", Inst, InstPC);
        else n_pass++;
        Stall = 1'b0; LoadEn = 1'b0;
        step();
        n_total++;
        if (Inst !== 32'h11111111 || InstValid !== 1'b1)
            $display("FAIL reload_c got %h/%b want 11111111/1", Inst, InstValid);
        else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [3];
        int          acks;
        data[0] = 32'hA0000001; data[1] = 32'hA0000002; data[2] = 32'hA0000003;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            LoadEn = 1'b1; LoadAddr = 32'h20 + 32'(i) * 32'd4; LoadData = data[i];
            step();
            if (LoadAck === 1'b1) acks++;
        end
        LoadEn = 1'b0;
        step();
        n_total++;
        if (acks != 3 || LoadAck !== 1'b0)
            $display("FAIL b2b_acks got %0d last %b want 3 0", acks, LoadAck);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            FetchEn = 1'b1; Addr = 32'h20 + 32'(i) * 32'd4;
            step();
            n_total++;
            if (Inst !== data[i] || InstValid !== 1'b1)
                $display("FAIL b2b_word%0d got %h want %h", i, Inst, data[i]);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_mid_clear_reset();
        int bad;
        bad = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        n_total++;
        if (Ready !== 1'b0 || InstValid !== 1'b0)
            $display("FAIL mid_reset got %b/%b want 0/0", Ready, InstValid);
        else n_pass++;
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (Ready !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL restart_window bad_edges %0d want 0", bad);
        else n_pass++;
        step();
        n_total++;
        if (Ready !== 1'b1) $display("FAIL restart_ready got %b want 1", Ready);
        else n_pass++;
        FetchEn = 1'b1; Addr = 32'h0;
        step();
        n_total++;
        if (Inst !== 32'd0 || InstValid !== 1'b1)
            $display("FAIL recleared got %h/%b want 0/1", Inst, InstValid);
        else n_pass++;
        idle();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_load_fetch();
        test_stall();
        test_flush();
        test_addr_err();
        test_collision();
        test_back_to_back();
        test_mid_clear_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
